// File: rtl/conv3x3_stream_layer.sv
// Row-streaming 3x3 convolution layer: a 3-row line buffer feeds one PE per output
// column; output channels are produced one per cycle, then the row is held for the consumer.

module conv3x3_pe #(
  parameter int VALUE_BITS = 32,
  parameter int FRAC_BITS  = 16,
  parameter int IN_CH      = 1,
  parameter int RELU       = 1
)(
  input  logic [2:0][2:0][IN_CH-1:0][VALUE_BITS-1:0] win,
  input  logic [IN_CH-1:0][2:0][2:0][VALUE_BITS-1:0] w,
  input  logic [VALUE_BITS-1:0]                      bias,
  output logic [VALUE_BITS-1:0]                      result
);
  localparam int ACC_W = 2*VALUE_BITS + $clog2(9*IN_CH);
  localparam int SUM_W = ACC_W + 1;
  localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-VALUE_BITS+1){1'b0}}, {(VALUE_BITS-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-VALUE_BITS+1){1'b1}}, {(VALUE_BITS-1){1'b0}}};

  logic signed [2*VALUE_BITS-1:0] prod;
  logic signed [ACC_W-1:0]        acc;
  logic signed [SUM_W-1:0]        sum;

  always_comb begin
    prod = '0;
    acc  = '0;
    for (int i = 0; i < IN_CH; i++)
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) begin
          prod = $signed(win[r][c][i]) * $signed(w[i][r][c]);
          acc  = acc + ACC_W'(prod);
        end
    // arithmetic shift floors toward -inf before the bias is added
    sum = SUM_W'(acc >>> FRAC_BITS) + SUM_W'($signed(bias));
    if (RELU != 0 && sum < 0) sum = '0;
    result = sum[VALUE_BITS-1:0];
    if (sum > SAT_MAX)      result = {1'b0, {(VALUE_BITS-1){1'b1}}};
    else if (sum < SAT_MIN) result = {1'b1, {(VALUE_BITS-1){1'b0}}};
  end
endmodule

module conv3x3_stream_layer #(
  parameter int VALUE_BITS  = 32,
  parameter int FRAC_BITS   = 16,
  parameter int INPUT_WIDTH = 28,
  parameter int IN_CH       = 1,
  parameter int OUT_CH      = 4,
  parameter int TAG_WIDTH   = 8,
  parameter int RELU        = 1,
  parameter logic [VALUE_BITS*OUT_CH*IN_CH*9-1:0] WEIGHTS = '0,
  parameter logic [VALUE_BITS*OUT_CH-1:0]         BIAS    = '0,
  localparam int OUTPUT_WIDTH = INPUT_WIDTH - 2
)(
  input  logic                                                clock_i,
  input  logic                                                reset_i,
  input  logic [INPUT_WIDTH-1:0][IN_CH-1:0][VALUE_BITS-1:0]   in_row_i,
  input  logic                                                in_row_valid_i,
  output logic                                                in_row_accept_o,
  input  logic                                                in_row_last_i,
  input  logic [TAG_WIDTH-1:0]                                in_row_tag_i,
  output logic [OUTPUT_WIDTH-1:0][OUT_CH-1:0][VALUE_BITS-1:0] out_row_o,
  output logic                                                out_row_valid_o,
  output logic                                                out_row_last_o,
  output logic [TAG_WIDTH-1:0]                                out_row_tag_o,
  input  logic                                                out_row_accept_i
);
  localparam int N_W  = OUT_CH*IN_CH*9;
  localparam int CH_W = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;

  typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} state_t;

  state_t state, next_state;
  logic [1:0] rows_held;
  logic [CH_W-1:0] ch;
  logic transfer, last_ch;
  logic [2:0][INPUT_WIDTH-1:0][IN_CH-1:0][VALUE_BITS-1:0] line_buf;
  logic [IN_CH-1:0][2:0][2:0][VALUE_BITS-1:0] cur_w;
  logic [VALUE_BITS-1:0] cur_bias;
  logic [OUTPUT_WIDTH-1:0][VALUE_BITS-1:0] pe_res;

  assign transfer = in_row_valid_i & in_row_accept_o;
  assign last_ch  = (ch == CH_W'(OUT_CH-1));

  always_ff @(posedge clock_i) begin
    if (reset_i) state <= LOAD;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      LOAD:    if (transfer && rows_held == 2'd2) next_state = COMPUTE;
      COMPUTE: if (last_ch) next_state = OUTPUT;
      OUTPUT:  if (out_row_accept_i) next_state = LOAD;
      default: next_state = LOAD;
    endcase
  end

  always_comb begin
    in_row_accept_o = (state == LOAD);
    out_row_valid_o = (state == OUTPUT);
  end

  // weights and bias of the channel being computed this cycle
  always_comb begin
    cur_w = '0;
    for (int i = 0; i < IN_CH; i++)
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          cur_w[i][r][c] = WEIGHTS[(N_W-1-(((int'(ch)*IN_CH+i)*3+r)*3+c))*VALUE_BITS +: VALUE_BITS];
    cur_bias = BIAS[(OUT_CH-1-int'(ch))*VALUE_BITS +: VALUE_BITS];
  end

  for (genvar j = 0; j < OUTPUT_WIDTH; j++) begin : g_col
    logic [2:0][2:0][IN_CH-1:0][VALUE_BITS-1:0] win;
    always_comb begin
      win = '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] = line_buf[r][j+c];
    end
    conv3x3_pe #(
      .VALUE_BITS(VALUE_BITS), .FRAC_BITS(FRAC_BITS), .IN_CH(IN_CH), .RELU(RELU)
    ) u_pe (
      .win(win), .w(cur_w), .bias(cur_bias), .result(pe_res[j])
    );
  end

  // line buffer carries no reset; rows_held alone decides which rows are live
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      if (state == LOAD && transfer)
        line_buf[rows_held] <= in_row_i;
      else if (state == OUTPUT && out_row_accept_i && !out_row_last_o) begin
        line_buf[0] <= line_buf[1];
        line_buf[1] <= line_buf[2];
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rows_held      <= '0;
      ch             <= '0;
      out_row_o      <= '0;
      out_row_last_o <= 1'b0;
      out_row_tag_o  <= '0;
    end else begin
      case (state)
        LOAD: if (transfer) begin
          if (rows_held == 2'd2) begin
            out_row_tag_o  <= in_row_tag_i;
            out_row_last_o <= in_row_last_i;
            ch             <= '0;
          end else if (in_row_last_i) begin
            rows_held <= '0;
          end else begin
            rows_held <= rows_held + 2'd1;
          end
        end
        COMPUTE: begin
          for (int j = 0; j < OUTPUT_WIDTH; j++)
            out_row_o[j][ch] <= pe_res[j];
          ch <= last_ch ? '0 : ch + CH_W'(1);
        end
        OUTPUT: if (out_row_accept_i)
          rows_held <= out_row_last_o ? 2'd0 : 2'd2;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_conv3x3_stream_layer.sv
// Directed bench: four parameterisations of the layer share one stimulus bus, selected by sel.
module tb_conv3x3_stream_layer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, in_vld, in_last, out_acc;
  logic [7:0] in_tag;
  logic [4:0][0:0][31:0] in_row;
  int sel;

  logic [3:0] acc_v, ov_v, ol_v;
  logic [7:0] ot0, ot1, ot2, ot3;
  logic [2:0][0:0][31:0] orow0;
  logic [2:0][1:0][31:0] orow1, orow2, orow3;

  logic cur_acc, cur_vld, cur_last;
  logic [7:0] cur_tag;
  logic [2:0][1:0][31:0] cur_row;

  int n_cmp = 0, n_err = 0;

  conv3x3_stream_layer #(.VALUE_BITS(32), .FRAC_BITS(16), .INPUT_WIDTH(5), .IN_CH(1), .OUT_CH(1),
    .TAG_WIDTH(8), .RELU(1), .WEIGHTS({{4{32'h0}}, 32'h00010000, {4{32'h0}}}), .BIAS(32'h0)
  ) u_id (
    .clock_i(clk), .reset_i(rst), .in_row_i(in_row), .in_row_valid_i(in_vld && sel == 0),
    .in_row_accept_o(acc_v[0]), .in_row_last_i(in_last), .in_row_tag_i(in_tag),
    .out_row_o(orow0), .out_row_valid_o(ov_v[0]), .out_row_last_o(ol_v[0]),
    .out_row_tag_o(ot0), .out_row_accept_i(out_acc && sel == 0));

  conv3x3_stream_layer #(.VALUE_BITS(32), .FRAC_BITS(16), .INPUT_WIDTH(5), .IN_CH(1), .OUT_CH(2),
    .TAG_WIDTH(8), .RELU(0), .WEIGHTS({18{32'h00010000}}), .BIAS({2{32'hFFF60000}})
  ) u_rb0 (
    .clock_i(clk), .reset_i(rst), .in_row_i(in_row), .in_row_valid_i(in_vld && sel == 1),
    .in_row_accept_o(acc_v[1]), .in_row_last_i(in_last), .in_row_tag_i(in_tag),
    .out_row_o(orow1), .out_row_valid_o(ov_v[1]), .out_row_last_o(ol_v[1]),
    .out_row_tag_o(ot1), .out_row_accept_i(out_acc && sel == 1));

  conv3x3_stream_layer #(.VALUE_BITS(32), .FRAC_BITS(16), .INPUT_WIDTH(5), .IN_CH(1), .OUT_CH(2),
    .TAG_WIDTH(8), .RELU(1), .WEIGHTS({18{32'h00010000}}), .BIAS({2{32'hFFF60000}})
  ) u_rb1 (
    .clock_i(clk), .reset_i(rst), .in_row_i(in_row), .in_row_valid_i(in_vld && sel == 2),
    .in_row_accept_o(acc_v[2]), .in_row_last_i(in_last), .in_row_tag_i(in_tag),
    .out_row_o(orow2), .out_row_valid_o(ov_v[2]), .out_row_last_o(ol_v[2]),
    .out_row_tag_o(ot2), .out_row_accept_i(out_acc && sel == 2));

  conv3x3_stream_layer #(.VALUE_BITS(32), .FRAC_BITS(16), .INPUT_WIDTH(5), .IN_CH(1), .OUT_CH(2),
    .TAG_WIDTH(8), .RELU(0), .WEIGHTS({18{32'h7FFFFFFF}}), .BIAS({2{32'h0}})
  ) u_sat (
    .clock_i(clk), .reset_i(rst), .in_row_i(in_row), .in_row_valid_i(in_vld && sel == 3),
    .in_row_accept_o(acc_v[3]), .in_row_last_i(in_last), .in_row_tag_i(in_tag),
    .out_row_o(orow3), .out_row_valid_o(ov_v[3]), .out_row_last_o(ol_v[3]),
    .out_row_tag_o(ot3), .out_row_accept_i(out_acc && sel == 3));

  always_comb begin
    cur_acc = 1'b0; cur_vld = 1'b0; cur_last = 1'b0; cur_tag = '0; cur_row = '0;
    case (sel)
      0: begin
        cur_acc = acc_v[0]; cur_vld = ov_v[0]; cur_last = ol_v[0]; cur_tag = ot0;
        for (int j = 0; j < 3; j++) cur_row[j][0] = orow0[j][0];
      end
      1: begin cur_acc = acc_v[1]; cur_vld = ov_v[1]; cur_last = ol_v[1]; cur_tag = ot1; cur_row = orow1; end
      2: begin cur_acc = acc_v[2]; cur_vld = ov_v[2]; cur_last = ol_v[2]; cur_tag = ot2; cur_row = orow2; end
      3: begin cur_acc = acc_v[3]; cur_vld = ov_v[3]; cur_last = ol_v[3]; cur_tag = ot3; cur_row = orow3; end
      default: ;
    endcase
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic push(input logic last, input logic [7:0] tag);
    int n;
    in_tag = tag; in_last = last; in_vld = 1'b1;
    n = 0;
    while (!cur_acc && n < 40) begin tick(); n++; end
    chk("in_accept_wait", {31'b0, cur_acc}, 32'd1);
    tick();
    in_vld = 1'b0; in_last = 1'b0;
  endtask

  task automatic fill_const(input logic [31:0] v);
    for (int j = 0; j < 5; j++) in_row[j][0] = v;
  endtask

  task automatic fill_id(input int k);
    for (int j = 0; j < 5; j++) in_row[j][0] = 32'(65536 * (10*k + j));
  endtask

  task automatic const_frame(input logic [31:0] v, input logic [7:0] tag);
    fill_const(v);
    push(1'b0, tag); push(1'b0, tag + 8'd1); push(1'b1, tag + 8'd2);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!cur_vld && n < 40) begin tick(); n++; end
    chk("out_valid_wait", {31'b0, cur_vld}, 32'd1);
  endtask

  task automatic take_out();
    out_acc = 1'b1; tick(); out_acc = 1'b0;
    chk("valid_drop", {31'b0, cur_vld}, 32'd0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_valid"}, {31'b0, cur_vld}, 32'd0);
    chk({nm, "_last"}, {31'b0, cur_last}, 32'd0);
    chk({nm, "_tag"}, {24'b0, cur_tag}, 32'd0);
    chk({nm, "_inacc"}, {31'b0, cur_acc}, 32'd1);
    for (int j = 0; j < 3; j++)
      for (int o = 0; o < 2; o++) chk({nm, "_data"}, cur_row[j][o], 32'd0);
  endtask

  task automatic chk_row(input string nm, input int nch, input logic [31:0] exp);
    for (int j = 0; j < 3; j++)
      for (int o = 0; o < nch; o++) chk(nm, cur_row[j][o], exp);
  endtask

  typedef struct {
    int          inst;
    logic [31:0] din;
    logic [31:0] dout;
    logic [7:0]  tag;
  } vec_t;

  vec_t vt[8];

  initial begin
    int n, nch;
    logic [31:0] hold_d;
    vt[0] = '{1, 32'h00010000, 32'hFFFF0000, 8'h10};
    vt[1] = '{2, 32'h00010000, 32'h00000000, 8'h20};
    vt[2] = '{3, 32'h7FFFFFFF, 32'h7FFFFFFF, 8'h30};
    vt[3] = '{3, 32'h80000000, 32'h80000000, 8'h40};
    vt[4] = '{1, 32'h00000000, 32'hFFF60000, 8'h50};
    vt[5] = '{2, 32'h00020000, 32'h00080000, 8'h60};
    vt[6] = '{1, 32'hFFFF0000, 32'hFFED0000, 8'h70};
    vt[7] = '{2, 32'hFFFF0000, 32'h00000000, 8'h80};

    rst = 1'b1; in_vld = 1'b0; in_last = 1'b0; in_tag = '0; out_acc = 1'b0; sel = 0; in_row = '0;
    tick(); do_reset();
    for (int s = 0; s < 4; s++) begin sel = s; #1; chk_zero("reset"); end

    // identity frame, backpressure on the first output row
    sel = 0; #1;
    fill_id(0); push(1'b0, 8'hA0);
    fill_id(1); push(1'b0, 8'hA1);
    for (int k = 2; k < 5; k++) begin
      fill_id(k); push(k == 4, 8'(8'hA0 + k));
      wait_valid(n);
      chk("id_latency", 32'(n), 32'd1);
      for (int j = 0; j < 3; j++) chk("id_data", cur_row[j][0], 32'(65536 * (10*(k-1) + j + 1)));
      chk("id_last", {31'b0, cur_last}, {31'b0, k == 4});
      chk("id_tag", {24'b0, cur_tag}, 32'(8'hA0 + k));
      if (k == 2) begin
        hold_d = cur_row[1][0];
        for (int c = 0; c < 10; c++) begin
          tick();
          chk("bp_valid", {31'b0, cur_vld}, 32'd1);
          chk("bp_data", cur_row[1][0], hold_d);
          chk("bp_tag", {24'b0, cur_tag}, 32'hA2);
          chk("bp_last", {31'b0, cur_last}, 32'd0);
          chk("bp_inacc", {31'b0, cur_acc}, 32'd0);
        end
      end
      take_out();
      chk("id_inacc_back", {31'b0, cur_acc}, 32'd1);
    end
    for (int c = 0; c < 5; c++) begin tick(); chk("id_no_extra", {31'b0, cur_vld}, 32'd0); end

    // short frame is discarded; the next full frame gives exactly one row
    fill_id(7); push(1'b0, 8'hB0);
    fill_id(8); push(1'b1, 8'hB1);
    for (int c = 0; c < 5; c++) begin tick(); chk("short_no_out", {31'b0, cur_vld}, 32'd0); end
    fill_id(5); push(1'b0, 8'hC0);
    fill_id(6); push(1'b0, 8'hC1);
    fill_id(7); push(1'b1, 8'hC2);
    wait_valid(n);
    for (int j = 0; j < 3; j++) chk("short_next_data", cur_row[j][0], 32'(65536 * (60 + j + 1)));
    chk("short_next_last", {31'b0, cur_last}, 32'd1);
    chk("short_next_tag", {24'b0, cur_tag}, 32'hC2);
    take_out();
    for (int c = 0; c < 5; c++) begin tick(); chk("short_single", {31'b0, cur_vld}, 32'd0); end

    // vector table: constant frames through the arithmetic variants
    foreach (vt[v]) begin
      sel = vt[v].inst; #1;
      nch = (sel == 0) ? 1 : 2;
      do_reset();
      const_frame(vt[v].din, vt[v].tag);
      wait_valid(n);
      chk("vec_latency", 32'(n), 32'(nch));
      chk_row("vec_data", nch, vt[v].dout);
      chk("vec_last", {31'b0, cur_last}, 32'd1);
      chk("vec_tag", {24'b0, cur_tag}, {24'b0, vt[v].tag + 8'd2});
      take_out();
    end

    // reset mid-COMPUTE
    sel = 1; #1;
    do_reset();
    const_frame(32'h00010000, 8'hD0);
    chk("midc_in_compute", {31'b0, cur_acc}, 32'd0);
    do_reset();
    chk_zero("midc");
    const_frame(32'h00010000, 8'hD4);
    wait_valid(n);
    chk_row("midc_next_data", 2, 32'hFFFF0000);
    chk("midc_next_tag", {24'b0, cur_tag}, 32'hD6);
    chk("midc_next_last", {31'b0, cur_last}, 32'd1);
    take_out();

    // reset mid-OUTPUT
    const_frame(32'h00010000, 8'hE0);
    wait_valid(n);
    do_reset();
    chk_zero("mido");
    const_frame(32'h00020000, 8'hE4);
    wait_valid(n);
    chk_row("mido_next_data", 2, 32'h00080000);
    chk("mido_next_tag", {24'b0, cur_tag}, 32'hE6);
    take_out();
    for (int c = 0; c < 5; c++) begin tick(); chk("mido_single", {31'b0, cur_vld}, 32'd0); end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
